// File: rtl/pkt_pkg.sv
// Shared definitions for the packet builder: FSM states, data_sel encodings,
// bytes-per-word decode and the default CRC8 polynomial.
package pkt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        CRC     = 3'd3,
        WR_REQ  = 3'd4,
        WR_DATA = 3'd5,
        FINISH  = 3'd6
    } state_t;

    localparam logic [3:0] OP0 = 4'd0;
    localparam logic [3:0] OP1 = 4'd1;
    localparam logic [3:0] OP2 = 4'd2;

    localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;

    // Two header bytes + up to 16 payload bytes + CRC byte, padded to 5 words.
    localparam int BUF_BYTES = 20;

    // Zero marks an illegal data_sel.
    function automatic logic [2:0] bytes_per_word(input logic [3:0] sel);
        case (sel)
            OP0:     return 3'd1;
            OP1:     return 3'd2;
            OP2:     return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/crc8_byte.sv
// Single-byte CRC8 update, MSB first, no reflection.
module crc8_byte #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/packet_build_ctrl.sv
// Reads a payload burst, prepends a two-byte header, appends a CRC8 and
// writes the packed packet back out as a little-endian word burst.
module packet_build_ctrl
    import pkt_pkg::*;
#(
    parameter logic [7:0] CRC_POLY = CRC_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  byte_cnt,
    input  logic [3:0]  data_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arlen,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    input  logic        rlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [2:0]  awlen,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    output logic        wlast
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [2:0]  bpw_q;
    logic [7:0]  buf_q [BUF_BYTES];
    logic [4:0]  ptr_q;
    logic [4:0]  rd_beat_q;
    logic [2:0]  wr_beat_q;
    logic [7:0]  crc_q;
    logic        err_q;

    logic [4:0]  len, rd_beats, rd_last, remaining, wbase;
    logic [2:0]  wr_last, take;
    logic [7:0]  crc_seed;
    logic [7:0]  chain_in [4];
    logic [39:0] chain;

    always_comb begin
        len = {1'b0, cnt_q} + 5'd1;
        case (bpw_q)
            3'd1:    rd_beats = len;
            3'd2:    rd_beats = (len + 5'd1) >> 1;
            default: rd_beats = (len + 5'd3) >> 2;
        endcase
        rd_last   = rd_beats - 5'd1;
        wr_last   = 3'((len + 5'd2) >> 2);
        // ptr_q starts at 2, so payload bytes still owed = len - (ptr_q - 2).
        remaining = len + 5'd2 - ptr_q;
        take      = (remaining > {2'b00, bpw_q}) ? bpw_q : remaining[2:0];
        wbase     = {wr_beat_q, 2'b00};
    end

    // The same chain seeds the CRC from the header in IDLE and folds read lanes later.
    always_comb begin
        crc_seed = crc_q;
        for (int i = 0; i < 4; i++) begin
            chain_in[i] = rdata[8*i +: 8];
        end
        if (state_q == IDLE) begin
            crc_seed    = 8'h00;
            chain_in[0] = {4'h0, data_sel};
            chain_in[1] = {4'h0, byte_cnt};
        end
    end

    assign chain[7:0] = crc_seed;

    for (genvar g = 0; g < 4; g++) begin : g_crc
        crc8_byte #(.POLY(CRC_POLY)) u_crc (
            .crc_in  (chain[8*g +: 8]),
            .data_in (chain_in[g]),
            .crc_out (chain[8*(g+1) +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        err     = err_q;
        arvalid = 1'b0;
        arlen   = 4'd0;
        rready  = 1'b0;
        awvalid = 1'b0;
        awlen   = 3'd0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        wdata   = 32'h0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (bytes_per_word(data_sel) == 3'd0) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                arvalid = 1'b1;
                arlen   = rd_last[3:0];
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid && (rd_beat_q == rd_last)) state_d = CRC;
            end
            CRC: state_d = WR_REQ;
            WR_REQ: begin
                awvalid = 1'b1;
                awlen   = wr_last;
                if (awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                wvalid = 1'b1;
                wdata  = {buf_q[wbase + 5'd3], buf_q[wbase + 5'd2],
                          buf_q[wbase + 5'd1], buf_q[wbase]};
                wlast  = (wr_beat_q == wr_last);
                if (wready && wlast) state_d = FINISH;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 4'd0;
            bpw_q     <= 3'd0;
            ptr_q     <= 5'd0;
            rd_beat_q <= 5'd0;
            wr_beat_q <= 3'd0;
            crc_q     <= 8'h00;
            err_q     <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q     <= byte_cnt;
                        bpw_q     <= bytes_per_word(data_sel);
                        ptr_q     <= 5'd2;
                        rd_beat_q <= 5'd0;
                        wr_beat_q <= 3'd0;
                        crc_q     <= chain[23:16];
                        err_q     <= (bytes_per_word(data_sel) == 3'd0);
                        // Clearing the whole buffer keeps the tail padding at zero.
                        for (int i = 2; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
                        buf_q[0]  <= {4'h0, data_sel};
                        buf_q[1]  <= {4'h0, byte_cnt};
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        for (int i = 0; i < 4; i++) begin
                            if (3'(i) < take) buf_q[ptr_q + 5'(i)] <= rdata[8*i +: 8];
                        end
                        ptr_q     <= ptr_q + {2'b00, take};
                        crc_q     <= chain[{take, 3'b000} +: 8];
                        rd_beat_q <= rd_beat_q + 5'd1;
                        if (rlast != (rd_beat_q == rd_last)) err_q <= 1'b1;
                    end
                end
                CRC:     buf_q[ptr_q] <= crc_q;
                WR_DATA: if (wready) wr_beat_q <= wr_beat_q + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_build_ctrl.sv
// Randomized bench for packet_build_ctrl with a packet-image reference model.
module tb_packet_build_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  byte_cnt, data_sel;
    logic        busy, done, err;
    logic        arvalid, arready;
    logic [3:0]  arlen;
    logic [31:0] rdata;
    logic        rvalid, rready, rlast;
    logic        awvalid, awready;
    logic [2:0]  awlen;
    logic [31:0] wdata;
    logic        wvalid, wready, wlast;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_build_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .byte_cnt(byte_cnt), .data_sel(data_sel),
        .busy(busy), .done(done), .err(err),
        .arvalid(arvalid), .arready(arready), .arlen(arlen),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awlen(awlen),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast)
    );

    function automatic logic [7:0] crc8_ref(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        foreach (q[i]) begin
            c = c ^ q[i];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Runs one job as the bus slave; bad_beat >= 0 puts rlast on that beat only.
    task automatic do_job(input logic [3:0] sel, input logic [3:0] cnt, input int bad_beat,
                          input bit stall, input bit zero_data, input bit abort_wr,
                          input string tag);
        int L, bpw, R, W, rd_idx, wr_idx, ar_hs, aw_hs, base;
        bit legal, exp_err, finished, aborted;
        logic [7:0] payload [16];
        logic [7:0] img [20];
        logic [7:0] q [$];
        logic [31:0] rword, exp_word;

        L     = int'(cnt) + 1;
        legal = (sel <= 4'd2);
        bpw   = (sel == 4'd0) ? 1 : (sel == 4'd1) ? 2 : 4;
        R     = (L + bpw - 1) / bpw;
        W     = (L + 6) / 4;
        for (int i = 0; i < 16; i++) payload[i] = zero_data ? 8'h00 : 8'($urandom);
        for (int i = 0; i < 20; i++) img[i] = 8'h00;
        img[0] = {4'h0, sel};
        img[1] = {4'h0, cnt};
        for (int i = 0; i < L; i++) img[2+i] = payload[i];
        q = {};
        for (int i = 0; i < L + 2; i++) q.push_back(img[i]);
        img[L+2] = crc8_ref(q);
        exp_err = !legal || (bad_beat >= 0 && bad_beat != R - 1);

        @(negedge clk);
        start = 1'b1; data_sel = sel; byte_cnt = cnt;
        @(negedge clk);
        rd_idx = 0; wr_idx = 0; ar_hs = 0; aw_hs = 0; finished = 0; aborted = 0;

        for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
            if (done) begin
                finished = 1;
                start = 1'b0; arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0;
                checks++;
                if (err !== exp_err) begin
                    failures++; $display("FAIL %s err: got %b want %b", tag, err, exp_err);
                end
                if (legal) begin
                    checks++;
                    if (rd_idx != R || wr_idx != W || ar_hs != 1 || aw_hs != 1) begin
                        failures++;
                        $display("FAIL %s beats: rd=%0d/%0d wr=%0d/%0d ar=%0d aw=%0d", tag, rd_idx, R, wr_idx, W, ar_hs, aw_hs);
                    end
                end else begin
                    checks++;
                    if (cyc > 1 || ar_hs != 0 || aw_hs != 0 || wr_idx != 0) begin
                        failures++;
                        $display("FAIL %s illegal: done_cycle=%0d ar=%0d aw=%0d wr=%0d want <=1/0/0/0", tag, cyc, ar_hs, aw_hs, wr_idx);
                    end
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL %s busy: got %b want 1", tag, busy);
                end
                if (!legal && (arvalid || awvalid || wvalid)) begin
                    checks++; failures++;
                    $display("FAIL %s illegal_bus: ar=%b aw=%b w=%b want 000", tag, arvalid, awvalid, wvalid);
                end
                if (arvalid) begin
                    checks++;
                    if (arlen !== 4'(R - 1)) begin
                        failures++; $display("FAIL %s arlen: got %0d want %0d", tag, arlen, R - 1);
                    end
                end
                arready = arvalid && (!stall || $urandom_range(0, 2) == 0);
                if (arvalid && arready) ar_hs++;

                if (rready) begin
                    rvalid = !stall || ($urandom_range(0, 1) == 1);
                    rword  = zero_data ? 32'h0 : $urandom;
                    for (int k = 0; k < 4; k++) begin
                        if (k < bpw && rd_idx * bpw + k < L) rword[8*k +: 8] = payload[rd_idx * bpw + k];
                    end
                    rdata = rword;
                    rlast = (bad_beat >= 0) ? (rd_idx == bad_beat) : (rd_idx == R - 1);
                    if (rvalid) begin
                        checks++;
                        if (rd_idx >= R) begin
                            failures++; $display("FAIL %s read_overrun: beat %0d want < %0d", tag, rd_idx, R);
                        end
                        rd_idx++;
                    end
                end else begin
                    rvalid = 1'b0;
                end

                if (awvalid) begin
                    checks++;
                    if (awlen !== 3'(W - 1)) begin
                        failures++; $display("FAIL %s awlen: got %0d want %0d", tag, awlen, W - 1);
                    end
                end
                awready = awvalid && (!stall || $urandom_range(0, 2) == 0);
                if (awvalid && awready) aw_hs++;

                if (wvalid && abort_wr) begin
                    aborted = 1;
                    wready = 1'b0;
                end else if (wvalid) begin
                    checks++;
                    if (wr_idx >= W) begin
                        failures++; $display("FAIL %s write_overrun: beat %0d want < %0d", tag, wr_idx, W);
                    end else begin
                        base = 4 * wr_idx;
                        exp_word = {img[base+3], img[base+2], img[base+1], img[base]};
                        if (wdata !== exp_word) begin
                            failures++; $display("FAIL %s wdata[%0d]: got %h want %h", tag, wr_idx, wdata, exp_word);
                        end
                        checks++;
                        if (wlast !== (wr_idx == W - 1)) begin
                            failures++; $display("FAIL %s wlast[%0d]: got %b want %b", tag, wr_idx, wlast, wr_idx == W - 1);
                        end
                    end
                    wready = !stall || ($urandom_range(0, 1) == 1);
                    if (wready) wr_idx++;
                end else begin
                    wready = 1'b0;
                end

                start    = 1'($urandom_range(0, 1));
                data_sel = 4'($urandom);
                byte_cnt = 4'($urandom);
            end
            if (!finished && !aborted) @(negedge clk);
        end

        if (aborted) begin
            start = 1'b0; reset = 1'b1;
            @(negedge clk);
            checks++;
            if (wvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++; $display("FAIL %s abort: wvalid=%b busy=%b done=%b want 000", tag, wvalid, busy, done);
            end
            reset = 1'b0; arready = 1'b0; rvalid = 1'b0; awready = 1'b0;
            repeat (3) begin
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    failures++; $display("FAIL %s post_abort: done=%b busy=%b want 00", tag, done, busy);
                end
            end
        end else if (!finished) begin
            checks++; failures++;
            $display("FAIL %s timeout: done not seen in 400 cycles, want done", tag);
            start = 1'b0; reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end else begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
                failures++;
                $display("FAIL %s after_done: done=%b busy=%b err=%b want 0 0 %b", tag, done, busy, err, exp_err);
            end
        end
    endtask

    task automatic test_reset(input string tag);
        start = 1'b1; data_sel = 4'd2; byte_cnt = 4'd7;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, arvalid, rready, awvalid, wvalid, wlast} !== 8'h00) begin
            failures++;
            $display("FAIL %s ctrl: got %b want 00000000", tag, {busy, done, err, arvalid, rready, awvalid, wvalid, wlast});
        end
        checks++;
        if (arlen !== 4'd0 || awlen !== 3'd0 || wdata !== 32'h0) begin
            failures++; $display("FAIL %s data: arlen=%0d awlen=%0d wdata=%h want 0 0 0", tag, arlen, awlen, wdata);
        end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_min_job();
        do_job(4'd0, 4'd0, -1, 1'b0, 1'b1, 1'b0, "min_job");
    endtask

    task automatic test_max_job();
        do_job(4'd2, 4'd15, -1, 1'b1, 1'b0, 1'b0, "max_job");
    endtask

    task automatic test_partial_beat();
        do_job(4'd1, 4'd4, -1, 1'b1, 1'b0, 1'b0, "partial_beat");
    endtask

    task automatic test_illegal_sel();
        do_job(4'h5, 4'($urandom), -1, 1'b0, 1'b0, 1'b0, "illegal_5");
        do_job(4'hF, 4'($urandom), -1, 1'b0, 1'b0, 1'b0, "illegal_f");
    endtask

    task automatic test_rlast_error();
        do_job(4'd0, 4'd3, 1, 1'b0, 1'b0, 1'b0, "rlast_early");
        do_job(4'd2, 4'd9, 0, 1'b1, 1'b0, 1'b0, "rlast_missing");
    endtask

    task automatic test_reset_mid_write();
        do_job(4'd0, 4'd3, -1, 1'b0, 1'b0, 1'b1, "abort_write");
        do_job(4'd0, 4'd3, -1, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            do_job(4'($urandom_range(0, 2)), 4'($urandom),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : -1,
                   1'($urandom_range(0, 1)), 1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            do_job(4'($urandom_range(0, 2)), 4'($urandom), -1, 1'b0, 1'b0, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_cnt = 4'd0; data_sel = 4'd0;
        arready = 1'b0; rdata = 32'h0; rvalid = 1'b0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0;
        test_reset("reset_initial");
        test_min_job();
        test_max_job();
        test_partial_beat();
        test_illegal_sel();
        test_rlast_error();
        test_reset("reset_after_err");
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
